// File: rtl/bus_mux_reg_if.sv
// ---------------------------------------------------------------------------
// bus_mux_reg_if
// Groups the bus-side signals of the registered bus multiplexer so the
// multiplexer and whoever drives it share one bundle.
//
// Signals:
//   i_src_out       N        out-enables, bit i requests source i
//   i_bus_in        N*WIDTH  flattened sources, source i at [i*WIDTH +: WIDTH]
//   i_err_clr       1        synchronous clear of sticky flag and counter
//   o_bus_out       WIDTH    registered bus value
//   o_enc_out       SEL_W    registered winner index
//   o_bus_valid     1        an enable was set in the previous cycle
//   o_conflict      1        several enables were set in the previous cycle
//   o_conflict_sticky 1      latched conflict flag
//   o_conflict_cnt  CNT_W    saturating conflict counter
//   i_par_chk_in / o_bus_par exist only when BUS_MUX_PARITY_EN is defined
//
// Modports: master drives the sources and reads results, slave is the mux.
// ---------------------------------------------------------------------------
interface bus_mux_reg_if #(
    parameter int N     = 24,
    parameter int WIDTH = 32,
    parameter int SEL_W = 5,
    parameter int CNT_W = 8
);
    logic [N-1:0]       i_src_out;
    logic [N*WIDTH-1:0] i_bus_in;
    logic               i_err_clr;
    logic [WIDTH-1:0]   o_bus_out;
    logic [SEL_W-1:0]   o_enc_out;
    logic               o_bus_valid;
    logic               o_conflict;
    logic               o_conflict_sticky;
    logic [CNT_W-1:0]   o_conflict_cnt;
`ifdef BUS_MUX_PARITY_EN
    logic               i_par_chk_in;
    logic               o_bus_par;

    modport master (
        output i_src_out, i_bus_in, i_err_clr, i_par_chk_in,
        input  o_bus_out, o_enc_out, o_bus_valid, o_conflict,
               o_conflict_sticky, o_conflict_cnt, o_bus_par
    );

    modport slave (
        input  i_src_out, i_bus_in, i_err_clr, i_par_chk_in,
        output o_bus_out, o_enc_out, o_bus_valid, o_conflict,
               o_conflict_sticky, o_conflict_cnt, o_bus_par
    );
`else
    modport master (
        output i_src_out, i_bus_in, i_err_clr,
        input  o_bus_out, o_enc_out, o_bus_valid, o_conflict,
               o_conflict_sticky, o_conflict_cnt
    );

    modport slave (
        input  i_src_out, i_bus_in, i_err_clr,
        output o_bus_out, o_enc_out, o_bus_valid, o_conflict,
               o_conflict_sticky, o_conflict_cnt
    );
`endif
endinterface

// File: rtl/bus_mux_reg.sv
// ---------------------------------------------------------------------------
// bus_mux_reg
// Registered N-source bus multiplexer with fixed priority (highest enabled
// index wins), selectable idle policy and multi-driver conflict detection
// with a sticky flag and a saturating counter. Every output comes from a
// flop, so there is no combinational input-to-output path.
//
// Ports:
//   clk   rising-edge clock
//   clr   asynchronous active-low reset, clears every output
//   bus   bus_mux_reg_if.slave bundle (enables, sources, err_clr, results)
//
// Optional feature macro: BUS_MUX_PARITY_EN
//   Adds o_bus_par (even parity of the next bus value) and i_par_chk_in;
//   a parity mismatch while bus_valid is high sets the sticky flag only.
// ---------------------------------------------------------------------------
module bus_mux_reg #(
    parameter int N           = 24,
    parameter int WIDTH       = 32,
    parameter int SEL_W       = 5,
    parameter int DEFAULT_IDX = 23,
    parameter int IDLE_MODE   = 0,
    parameter int CNT_W       = 8
) (
    input  logic         clk,
    input  logic         clr,
    bus_mux_reg_if.slave bus
);

    logic [SEL_W-1:0] w_winIdx;
    logic [WIDTH-1:0] w_winData;
    logic             w_any;
    logic             w_multi;
    logic [WIDTH-1:0] w_nextBus;
    logic [SEL_W-1:0] w_nextEnc;
    logic             w_parErr;
    logic             w_nextSticky;
    logic [CNT_W-1:0] w_nextCnt;

    logic [WIDTH-1:0] r_busOut;
    logic [SEL_W-1:0] r_encOut;
    logic             r_busValid;
    logic             r_conflict;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;
`ifdef BUS_MUX_PARITY_EN
    logic             r_busPar;
`endif

    // Priority encoder: scanning upward lets a higher enabled index overwrite
    // a lower one, so the last hit is the winner. Seeing a second hit marks
    // a multi-driver conflict.
    always_comb begin
        w_winIdx  = '0;
        w_winData = '0;
        w_any     = 1'b0;
        w_multi   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.i_src_out[i]) begin
                if (w_any) begin
                    w_multi = 1'b1;
                end
                w_any     = 1'b1;
                w_winIdx  = SEL_W'(i);
                w_winData = bus.i_bus_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next bus value and index: the winner when any enable is set, otherwise
    // the idle policy (default source, hold previous value, or zero).
    always_comb begin
        w_nextBus = r_busOut;
        w_nextEnc = r_encOut;
        if (w_any) begin
            w_nextBus = w_winData;
            w_nextEnc = w_winIdx;
        end else if (IDLE_MODE == 0) begin
            w_nextBus = bus.i_bus_in[DEFAULT_IDX*WIDTH +: WIDTH];
            w_nextEnc = SEL_W'(DEFAULT_IDX);
        end else if (IDLE_MODE == 2) begin
            w_nextBus = '0;
            w_nextEnc = '0;
        end
    end

    // Parity mismatch compares the checker input with what is currently on
    // the bus; without the parity option it can never fire.
    always_comb begin
`ifdef BUS_MUX_PARITY_EN
        w_parErr = r_busValid && (bus.i_par_chk_in != r_busPar);
`else
        w_parErr = 1'b0;
`endif
    end

    // Error bookkeeping: a new conflict (or parity error for the flag) beats
    // err_clr in the same cycle, so a clear-plus-conflict leaves a count of 1.
    // The counter stops at all-ones instead of wrapping.
    always_comb begin
        w_nextSticky = r_sticky;
        w_nextCnt    = r_cnt;
        if (bus.i_err_clr) begin
            w_nextSticky = 1'b0;
            w_nextCnt    = '0;
        end
        if (w_multi) begin
            w_nextSticky = 1'b1;
            if (bus.i_err_clr) begin
                w_nextCnt = CNT_W'(1);
            end else if (!(&r_cnt)) begin
                w_nextCnt = r_cnt + CNT_W'(1);
            end
        end
        if (w_parErr) begin
            w_nextSticky = 1'b1;
        end
    end

    // Output stage: everything is captured together so the outputs always
    // describe the same sampled cycle; reset clears all of it immediately.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_busOut   <= '0;
            r_encOut   <= '0;
            r_busValid <= 1'b0;
            r_conflict <= 1'b0;
            r_sticky   <= 1'b0;
            r_cnt      <= '0;
`ifdef BUS_MUX_PARITY_EN
            r_busPar   <= 1'b0;
`endif
        end else begin
            r_busOut   <= w_nextBus;
            r_encOut   <= w_nextEnc;
            r_busValid <= w_any;
            r_conflict <= w_multi;
            r_sticky   <= w_nextSticky;
            r_cnt      <= w_nextCnt;
`ifdef BUS_MUX_PARITY_EN
            r_busPar   <= ^w_nextBus;
`endif
        end
    end

    assign bus.o_bus_out         = r_busOut;
    assign bus.o_enc_out         = r_encOut;
    assign bus.o_bus_valid       = r_busValid;
    assign bus.o_conflict        = r_conflict;
    assign bus.o_conflict_sticky = r_sticky;
    assign bus.o_conflict_cnt    = r_cnt;
`ifdef BUS_MUX_PARITY_EN
    assign bus.o_bus_par         = r_busPar;
`endif

endmodule

// File: tb/tb_bus_mux_reg.sv
// ---------------------------------------------------------------------------
// tb_bus_mux_reg
// Drives three multiplexers in parallel from the same stimulus, one per idle
// policy (IDLE_MODE 0/1/2) with counter widths 8, 2 and 4, and compares them
// every cycle with a behavioural model of the bus rules.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bus_mux_reg;

    localparam int N           = 24;
    localparam int WIDTH       = 32;
    localparam int SEL_W       = 5;
    localparam int DEFAULT_IDX = 23;
    localparam int NINST       = 3;

    logic               clk;
    logic               tbClr;
    logic [N-1:0]       tbSrc;
    logic [N*WIDTH-1:0] tbData;
    logic               tbErrClr;
    logic               tbParChk;

    int vecCount;
    int missCount;

    int idleMode [NINST] = '{0, 1, 2};
    int cntMax   [NINST] = '{255, 3, 15};

    logic [WIDTH-1:0] expBus    [NINST];
    int               expEnc    [NINST];
    logic             expValid  [NINST];
    logic             expConf   [NINST];
    logic             expSticky [NINST];
    int               expCnt    [NINST];
    logic             expPar    [NINST];

    logic [WIDTH-1:0] obsBus    [NINST];
    logic [SEL_W-1:0] obsEnc    [NINST];
    logic             obsValid  [NINST];
    logic             obsConf   [NINST];
    logic             obsSticky [NINST];
    logic [7:0]       obsCnt    [NINST];
    logic             obsPar    [NINST];

    bus_mux_reg_if #(.N(N), .WIDTH(WIDTH), .SEL_W(SEL_W), .CNT_W(8)) ifA ();
    bus_mux_reg_if #(.N(N), .WIDTH(WIDTH), .SEL_W(SEL_W), .CNT_W(2)) ifB ();
    bus_mux_reg_if #(.N(N), .WIDTH(WIDTH), .SEL_W(SEL_W), .CNT_W(4)) ifC ();

    bus_mux_reg #(.N(N), .WIDTH(WIDTH), .SEL_W(SEL_W), .DEFAULT_IDX(DEFAULT_IDX),
                  .IDLE_MODE(0), .CNT_W(8)) dutA (.clk(clk), .clr(tbClr), .bus(ifA));
    bus_mux_reg #(.N(N), .WIDTH(WIDTH), .SEL_W(SEL_W), .DEFAULT_IDX(DEFAULT_IDX),
                  .IDLE_MODE(1), .CNT_W(2)) dutB (.clk(clk), .clr(tbClr), .bus(ifB));
    bus_mux_reg #(.N(N), .WIDTH(WIDTH), .SEL_W(SEL_W), .DEFAULT_IDX(DEFAULT_IDX),
                  .IDLE_MODE(2), .CNT_W(4)) dutC (.clk(clk), .clr(tbClr), .bus(ifC));

    // Shared stimulus fans out to all three interfaces.
    assign ifA.i_src_out = tbSrc;
    assign ifB.i_src_out = tbSrc;
    assign ifC.i_src_out = tbSrc;
    assign ifA.i_bus_in  = tbData;
    assign ifB.i_bus_in  = tbData;
    assign ifC.i_bus_in  = tbData;
    assign ifA.i_err_clr = tbErrClr;
    assign ifB.i_err_clr = tbErrClr;
    assign ifC.i_err_clr = tbErrClr;

    // Collect each instance's outputs into arrays so checks can loop.
    assign obsBus[0]    = ifA.o_bus_out;
    assign obsBus[1]    = ifB.o_bus_out;
    assign obsBus[2]    = ifC.o_bus_out;
    assign obsEnc[0]    = ifA.o_enc_out;
    assign obsEnc[1]    = ifB.o_enc_out;
    assign obsEnc[2]    = ifC.o_enc_out;
    assign obsValid[0]  = ifA.o_bus_valid;
    assign obsValid[1]  = ifB.o_bus_valid;
    assign obsValid[2]  = ifC.o_bus_valid;
    assign obsConf[0]   = ifA.o_conflict;
    assign obsConf[1]   = ifB.o_conflict;
    assign obsConf[2]   = ifC.o_conflict;
    assign obsSticky[0] = ifA.o_conflict_sticky;
    assign obsSticky[1] = ifB.o_conflict_sticky;
    assign obsSticky[2] = ifC.o_conflict_sticky;
    assign obsCnt[0]    = ifA.o_conflict_cnt;
    assign obsCnt[1]    = {6'd0, ifB.o_conflict_cnt};
    assign obsCnt[2]    = {4'd0, ifC.o_conflict_cnt};
`ifdef BUS_MUX_PARITY_EN
    assign ifA.i_par_chk_in = tbParChk;
    assign ifB.i_par_chk_in = tbParChk;
    assign ifC.i_par_chk_in = tbParChk;
    assign obsPar[0] = ifA.o_bus_par;
    assign obsPar[1] = ifB.o_bus_par;
    assign obsPar[2] = ifC.o_bus_par;
`else
    assign obsPar[0] = 1'b0;
    assign obsPar[1] = 1'b0;
    assign obsPar[2] = 1'b0;
`endif

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Model reset: every output of every instance goes to zero.
    task automatic modelReset();
        for (int k = 0; k < NINST; k++) begin
            expBus[k] = '0; expEnc[k] = 0; expValid[k] = 1'b0; expConf[k] = 1'b0;
            expSticky[k] = 1'b0; expCnt[k] = 0; expPar[k] = 1'b0;
        end
    endtask

    // Behavioural model of one sampled edge, using the stimulus present at
    // that edge: highest set index wins, popcount > 1 is a conflict.
    task automatic modelStep();
        int  winner;
        int  pc;
        logic parErr;
        winner = -1;
        for (int i = 0; i < N; i++) begin
            if (tbSrc[i]) winner = i;
        end
        pc = $countones(tbSrc);
        for (int k = 0; k < NINST; k++) begin
`ifdef BUS_MUX_PARITY_EN
            parErr = expValid[k] && (tbParChk != expPar[k]);
`else
            parErr = 1'b0;
`endif
            if (winner >= 0) begin
                expBus[k] = tbData[winner*WIDTH +: WIDTH];
                expEnc[k] = winner;
            end else if (idleMode[k] == 0) begin
                expBus[k] = tbData[DEFAULT_IDX*WIDTH +: WIDTH];
                expEnc[k] = DEFAULT_IDX;
            end else if (idleMode[k] == 2) begin
                expBus[k] = '0;
                expEnc[k] = 0;
            end
            expValid[k] = (winner >= 0);
            expConf[k]  = (pc > 1);
            if (tbErrClr) begin
                expSticky[k] = 1'b0;
                expCnt[k]    = 0;
            end
            if (pc > 1) begin
                expSticky[k] = 1'b1;
                expCnt[k]    = (expCnt[k] < cntMax[k]) ? expCnt[k] + 1 : cntMax[k];
            end
            if (parErr) expSticky[k] = 1'b1;
            expPar[k] = ^expBus[k];
        end
    endtask

    // Compare every output of every instance with the model.
    task automatic checkAll();
        for (int k = 0; k < NINST; k++) begin
            checkOutput($sformatf("bus_out[%0d]", k), 64'(obsBus[k]), 64'(expBus[k]));
            checkOutput($sformatf("enc_out[%0d]", k), 64'(obsEnc[k]), 64'(expEnc[k]));
            checkOutput($sformatf("bus_valid[%0d]", k), 64'(obsValid[k]), 64'(expValid[k]));
            checkOutput($sformatf("conflict[%0d]", k), 64'(obsConf[k]), 64'(expConf[k]));
            checkOutput($sformatf("sticky[%0d]", k), 64'(obsSticky[k]), 64'(expSticky[k]));
            checkOutput($sformatf("cnt[%0d]", k), 64'(obsCnt[k]), 64'(expCnt[k]));
`ifdef BUS_MUX_PARITY_EN
            checkOutput($sformatf("bus_par[%0d]", k), 64'(obsPar[k]), 64'(expPar[k]));
`endif
        end
    endtask

    // One cycle: drive on the falling edge, model the rising edge, sample 1ns later.
    task automatic applyStimulus(input logic [N-1:0] src, input logic errClr, input logic parChk);
        @(negedge clk);
        tbSrc    = src;
        tbErrClr = errClr;
        tbParChk = parChk;
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic setSource(input int idx, input logic [WIDTH-1:0] val);
        tbData[idx*WIDTH +: WIDTH] = val;
    endtask

    // Main sequence: reset, directed cases, random traffic, mid-run reset.
    initial begin
        logic [N-1:0] src;
        vecCount  = 0;
        missCount = 0;
        tbClr     = 1'b0;
        tbSrc     = '0;
        tbErrClr  = 1'b0;
        tbParChk  = 1'b0;
        for (int i = 0; i < N; i++) setSource(i, $urandom());
        modelReset();
        #2;
        checkAll();
        @(negedge clk);
        tbClr = 1'b1;

        // Single source 5.
        setSource(5, 32'hDEADBEEF);
        applyStimulus(N'(1) << 5, 1'b0, 1'b1);
        // Bits 3 and 17: priority plus conflict.
        setSource(17, 32'h12345678);
        applyStimulus((N'(1) << 3) | (N'(1) << 17), 1'b0, 1'b0);
        // Idle under all three policies.
        setSource(DEFAULT_IDX, 32'hCAFE0023);
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);

        // Clear, then five conflicts to walk the 2-bit counter into saturation.
        applyStimulus('0, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) applyStimulus(N'(3), 1'b0, 1'b0);
        applyStimulus(N'(1), 1'b1, 1'b1);
        applyStimulus(N'(6), 1'b1, 1'b0);

        // Parity: an odd-weight value, then a deliberately wrong checker bit.
        applyStimulus('0, 1'b1, 1'b0);
        setSource(0, 32'h00000007);
        applyStimulus(N'(1), 1'b0, 1'b0);
        applyStimulus(N'(1), 1'b0, 1'b0);
        applyStimulus(N'(1), 1'b0, 1'b1);

        // Random traffic: mix of idle, single and multiple enables.
        for (int v = 0; v < 300; v++) begin
            for (int i = 0; i < N; i++) setSource(i, $urandom());
            case ($urandom_range(3, 0))
                0: src = '0;
                1: begin src = '0; src[$urandom_range(N-1, 0)] = 1'b1; end
                default: src = N'($urandom());
            endcase
            applyStimulus(src, ($urandom_range(7, 0) == 0), 1'($urandom()));
        end

        // Mid-run asynchronous reset with source 0 requested.
        setSource(0, 32'hA5A50001);
        applyStimulus(N'(1), 1'b0, 1'b0);
        @(posedge clk);
        modelStep();
        #3;
        tbClr = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(posedge clk);
        #1;
        checkAll();
        @(negedge clk);
        tbClr = 1'b1;
        applyStimulus(N'(1), 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
